// File: rtl/streambuffer_pkg.sv
// Shared types and width helpers for the variable-length stream buffer.
// Provides byte_t, the default pop-size table and level/length widths.
package streambuffer_pkg;

  typedef logic [7:0] byte_t;

  localparam int NSZ_DEF = 4;
  localparam int SZ_LOG_DEF [NSZ_DEF] = '{2, 3, 4, 6};

  // width of a byte count that can reach the full capacity
  function automatic int lvl_w(input int bytes);
    return $clog2(bytes + 1);
  endfunction

  // width of a beat length field (1..ibytes)
  function automatic int len_w(input int ibytes);
    return $clog2(ibytes + 1);
  endfunction

endpackage

// File: rtl/sb_shift_merge.sv
// Combinational next-data path: shift out popped bytes, insert beat.
// Ports: data_in/data_out buffer images, pop_sel one-hot size, drain,
//        push/base/ilen/idata describe the beat written at byte base.
module sb_shift_merge
  import streambuffer_pkg::*;
#(
  parameter int BYTES = 256,
  parameter int IBYTES = 128,
  parameter int NSZ = 4,
  parameter int SZ_LOG [NSZ] = SZ_LOG_DEF,
  parameter int LW = 9,
  parameter int ILW = 8
) (
  input  byte_t            data_in [BYTES],
  input  logic [NSZ-1:0]   pop_sel,
  input  logic             drain,
  input  logic             push,
  input  logic [LW-1:0]    base,
  input  logic [ILW-1:0]   ilen,
  input  byte_t            idata [IBYTES],
  output byte_t            data_out [BYTES]
);

  localparam int IW = $clog2(IBYTES);

  byte_t         shifted [BYTES];
  logic [LW-1:0] off;
  logic [LW-1:0] lim;

  // one constant shift per pop size; a drain pop empties the buffer,
  // so its result is all zero regardless of the amount
  always_comb begin
    for (int i = 0; i < BYTES; i++) begin
      shifted[i] = data_in[i];
    end
    for (int k = 0; k < NSZ; k++) begin
      if (pop_sel[k]) begin
        for (int i = 0; i < BYTES; i++) begin
          if (i + (1 << SZ_LOG[k]) < BYTES) begin
            shifted[i] =
              data_in[(i + (1 << SZ_LOG[k])) % BYTES];
          end else begin
            shifted[i] = '0;
          end
        end
      end
    end
    if (drain) begin
      for (int i = 0; i < BYTES; i++) begin
        shifted[i] = '0;
      end
    end
  end

  always_comb begin
    off = '0;
    lim = base + LW'(ilen);
    for (int i = 0; i < BYTES; i++) begin
      data_out[i] = shifted[i];
      off = LW'(i) - base;
      if (push && LW'(i) >= base && LW'(i) < lim) begin
        data_out[i] = idata[off[IW-1:0]];
      end
    end
  end

endmodule

// File: rtl/streambuffer_varlen.sv
// Byte realignment buffer: variable-length beats in, fixed-size pops out.
// Ports: ivalid/idata/ilen/ilast/iready beat input; ovalid/oready per
//        pop size; odata oldest bytes; olevel fill; olast end-of-stream.
module streambuffer_varlen
  import streambuffer_pkg::*;
#(
  parameter int BYTES = 256,
  parameter int IBYTES = 128,
  parameter int NSZ = 4,
  parameter int SZ_LOG [NSZ] = SZ_LOG_DEF,
  localparam int OBYTES = 1 << SZ_LOG[NSZ-1],
  localparam int LW = lvl_w(BYTES),
  localparam int ILW = len_w(IBYTES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ivalid,
  input  byte_t          idata [IBYTES],
  input  logic [ILW-1:0] ilen,
  input  logic           ilast,
  output logic           iready,
  output logic [NSZ-1:0] ovalid,
  input  logic [NSZ-1:0] oready,
  output byte_t          odata [OBYTES],
  output logic [LW-1:0]  olevel,
  output logic           olast
);

  logic [LW-1:0]  count_r, count_n;
  logic           eos_r, eos_n;
  logic [NSZ-1:0] ovalid_r, ovalid_n;
  logic [NSZ-1:0] pop_sel;
  logic [LW-1:0]  pop_n;
  logic [LW-1:0]  base;
  logic           push, drain;
  byte_t          data_r [BYTES];
  byte_t          data_n [BYTES];

  assign iready = !eos_r
                  && count_r <= LW'(BYTES - IBYTES);
  assign push = ivalid && iready;

  // largest permitted requested size wins
  always_comb begin
    pop_sel = '0;
    for (int k = 0; k < NSZ; k++) begin
      if (ovalid_r[k] && oready[k]) begin
        pop_sel = '0;
        pop_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    pop_n = '0;
    for (int k = 0; k < NSZ; k++) begin
      if (pop_sel[k]) begin
        if (count_r < LW'(1 << SZ_LOG[k])) begin
          pop_n = count_r;
        end else begin
          pop_n = LW'(1 << SZ_LOG[k]);
        end
      end
    end
  end

  assign drain = |pop_sel && pop_n == count_r;
  assign base = count_r - pop_n;
  assign count_n = base + (push ? LW'(ilen) : '0);

  always_comb begin
    eos_n = eos_r;
    if (push && ilast) begin
      eos_n = 1'b1;
    end else if (count_n == '0) begin
      eos_n = 1'b0;
    end
  end

  always_comb begin
    ovalid_n = '0;
    for (int k = 0; k < NSZ; k++) begin
      ovalid_n[k] =
        (count_n >= LW'(1 << SZ_LOG[k]))
        || (eos_n && count_n != '0);
    end
  end

  sb_shift_merge #(
    .BYTES  (BYTES),
    .IBYTES (IBYTES),
    .NSZ    (NSZ),
    .SZ_LOG (SZ_LOG),
    .LW     (LW),
    .ILW    (ILW)
  ) u_merge (
    .data_in  (data_r),
    .pop_sel  (pop_sel),
    .drain    (drain),
    .push     (push),
    .base     (base),
    .ilen     (ilen),
    .idata    (idata),
    .data_out (data_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= '0;
      eos_r    <= 1'b0;
      ovalid_r <= '0;
      for (int i = 0; i < BYTES; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      count_r  <= count_n;
      eos_r    <= eos_n;
      ovalid_r <= ovalid_n;
      data_r   <= data_n;
    end
  end

  always_comb begin
    for (int i = 0; i < OBYTES; i++) begin
      odata[i] = data_r[i];
    end
  end

  assign ovalid = ovalid_r;
  assign olevel = count_r;
  assign olast  = eos_r;

  if (IBYTES > BYTES / 2) begin : g_ibytes_chk
    $error("IBYTES must be <= BYTES/2");
  end

  if (OBYTES > BYTES) begin : g_obytes_chk
    $error("largest pop size exceeds BYTES");
  end

  for (genvar k = 1; k < NSZ; k++) begin : g_sz_chk
    if (SZ_LOG[k] <= SZ_LOG[k-1]) begin : g_bad
      $error("SZ_LOG must be strictly increasing");
    end
  end

  a_ilen : assert property (
    @(posedge clk) disable iff (rst)
    ivalid |-> (ilen >= ILW'(1)
                && ilen <= ILW'(IBYTES))
  );

endmodule

// File: tb/tb_streambuffer_varlen.sv
// Directed table-driven bench for streambuffer_varlen.
// Each row is one cycle of stimulus and the state expected after it.
module tb_streambuffer_varlen;
  import streambuffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ivalid;
  byte_t      idata [128];
  logic [7:0] ilen;
  logic       ilast;
  logic       iready;
  logic [3:0] ovalid;
  logic [3:0] oready;
  byte_t      odata [64];
  logic [8:0] olevel;
  logic       olast;

  int total = 0;
  int bad = 0;

  streambuffer_varlen dut (
    .clk    (clk),
    .rst    (rst),
    .ivalid (ivalid),
    .idata  (idata),
    .ilen   (ilen),
    .ilast  (ilast),
    .iready (iready),
    .ovalid (ovalid),
    .oready (oready),
    .odata  (odata),
    .olevel (olevel),
    .olast  (olast)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       iv;
    int       len;
    bit       last;
    bit [3:0] ordy;
    int       base;
    int       lvl;
    bit [3:0] ov;
    bit       elast;
    bit       ir;
    int       d0;
  } vec_t;

  vec_t v [19];

  task automatic cmp(string tag, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  // odata must hold d0, d0+1, ... below lvl and zero above
  task automatic check_state(string tag, int lvl,
                             bit [3:0] ov, bit l,
                             bit ir, int d0);
    int nbad;
    int first;
    int want;
    cmp({tag, ".olevel"}, int'(olevel), lvl);
    cmp({tag, ".ovalid"}, int'(ovalid), int'(ov));
    cmp({tag, ".olast"}, int'(olast), int'(l));
    cmp({tag, ".iready"}, int'(iready), int'(ir));
    nbad = 0;
    first = -1;
    for (int i = 0; i < 64; i++) begin
      want = (i < lvl) ? ((d0 + i) & 255) : 0;
      if (int'(odata[i]) != want) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s.odata byte %0d got=%0d want=%0d",
        tag, first, odata[first],
        (first < lvl) ? ((d0 + first) & 255) : 0);
    end
  endtask

  task automatic drive(bit iv, int len, bit last,
                       bit [3:0] ordy, int base);
    ivalid = iv;
    ilen = 8'(len);
    ilast = last;
    oready = ordy;
    for (int j = 0; j < 128; j++) begin
      idata[j] = (j < len) ? byte_t'(base + j) : 8'hEE;
    end
  endtask

  function automatic vec_t mk(bit iv, int len, bit last,
                              bit [3:0] ordy, int base,
                              int lvl, bit [3:0] ov,
                              bit elast, bit ir, int d0);
    vec_t r;
    r.iv = iv; r.len = len; r.last = last;
    r.ordy = ordy; r.base = base; r.lvl = lvl;
    r.ov = ov; r.elast = elast; r.ir = ir; r.d0 = d0;
    return r;
  endfunction

  initial begin
    //           iv len lst ordy   base  lvl ov    l ir d0
    v[0]  = mk(1, 128, 0, 4'b0000, 0,   128, 4'hF, 0, 1, 0);
    v[1]  = mk(1, 128, 0, 4'b1000, 128, 192, 4'hF, 0, 0, 64);
    v[2]  = mk(1, 128, 0, 4'b1111, 0,   128, 4'hF, 0, 1, 128);
    v[3]  = mk(0, 1,   0, 4'b0001, 0,   124, 4'hF, 0, 1, 132);
    v[4]  = mk(0, 1,   0, 4'b0100, 0,   108, 4'hF, 0, 1, 148);
    v[5]  = mk(0, 1,   0, 4'b1000, 0,   44,  4'h7, 0, 1, 212);
    v[6]  = mk(0, 1,   0, 4'b0100, 0,   28,  4'h7, 0, 1, 228);
    v[7]  = mk(0, 1,   0, 4'b0100, 0,   12,  4'h3, 0, 1, 244);
    v[8]  = mk(0, 1,   0, 4'b0010, 0,   4,   4'h1, 0, 1, 252);
    v[9]  = mk(0, 1,   0, 4'b0001, 0,   0,   4'h0, 0, 1, 0);
    v[10] = mk(1, 5,   1, 4'b0000, 10,  5,   4'hF, 1, 0, 10);
    v[11] = mk(0, 1,   0, 4'b0001, 0,   1,   4'hF, 1, 0, 14);
    v[12] = mk(0, 1,   0, 4'b0100, 0,   0,   4'h0, 0, 1, 0);
    v[13] = mk(1, 3,   0, 4'b0000, 20,  3,   4'h0, 0, 1, 20);
    v[14] = mk(1, 3,   0, 4'b0000, 23,  6,   4'h1, 0, 1, 20);
    v[15] = mk(1, 2,   1, 4'b0001, 26,  4,   4'hF, 1, 0, 24);
    v[16] = mk(0, 1,   0, 4'b1111, 0,   0,   4'h0, 0, 1, 0);
    v[17] = mk(1, 128, 0, 4'b0000, 0,   128, 4'hF, 0, 1, 0);
    v[18] = mk(1, 72,  1, 4'b0000, 128, 200, 4'hF, 1, 0, 0);

    rst = 1'b1;
    drive(0, 1, 0, 4'b0000, 0);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 4'h0, 0, 1, 0);
    rst = 1'b0;

    for (int n = 0; n < 19; n++) begin
      drive(v[n].iv, v[n].len, v[n].last,
            v[n].ordy, v[n].base);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", n), v[n].lvl,
                  v[n].ov, v[n].elast, v[n].ir, v[n].d0);
    end

    // reset while full with end-of-stream and a pop requested
    rst = 1'b1;
    drive(0, 1, 0, 4'b1111, 0);
    @(posedge clk);
    #1;
    check_state("rst_mid", 0, 4'h0, 0, 1, 0);

    rst = 1'b0;
    drive(0, 1, 0, 4'b0000, 0);
    @(posedge clk);
    #1;
    check_state("post_rst_idle", 0, 4'h0, 0, 1, 0);

    drive(1, 4, 0, 4'b0000, 50);
    @(posedge clk);
    #1;
    check_state("post_rst_push", 4, 4'h1, 0, 1, 50);

    drive(0, 1, 0, 4'b0000, 0);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
